ca_sprite_ram: RTL and testbench

- Owns the 1024x16 bitmap RAM that the 128x128 sprite display layer reads through its prefetch port.
- Answers prefetch reads with fixed one-cycle latency.
- Fills the RAM with a 1-D elementary cellular automaton: row 0 is the seed, and row y+1 is rule(row y), for 128 rows.
- Sits between the CA controller (start/done) and the sprite renderer (prefetch_now/prefetch_addr/prefetch_data).

---
 rtl/ca_sprite_ram.sv | 161 ++++++++++++++++
 tb/tb_ca_sprite_ram.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ca_sprite_ram.sv
// ca_sprite_ram: 1024x16 sprite bitmap RAM filled by a 1-D elementary
// cellular automaton (128 rows of 128 cells), with a one-cycle-latency
// prefetch read port for the sprite renderer. Reads always win over writes.
// Optional feature macro: CA_LFSR_SEED_EN (seed row from a 16-bit LFSR
// over 8 SEED cycles instead of a single live cell at SEED_X).
module ca_sprite_ram #(
    parameter logic [7:0]  RULE   = 8'd30,
    parameter int unsigned SEED_X = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        prefetch_now,
    input  logic [9:0]  prefetch_addr,
    output logic [15:0] prefetch_data,
    output logic        busy,
    output logic        done,
    output logic [6:0]  row
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SEED  = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_NEXT  = 3'd3;
    localparam logic [2:0] S_FIN   = 3'd4;

    logic [2:0]   state;
    logic [2:0]   w;
    logic [127:0] cur_row;
    logic [127:0] nxt_row;
    logic [15:0]  wr_word;
    logic         wr_en;
    logic [15:0]  mem [0:1023];

    // Unwritten words read back as zero from configuration onwards
    initial begin
        for (int unsigned i = 0; i < 1024; i++) begin
            mem[i] = '0;
        end
    end

`ifdef CA_LFSR_SEED_EN
    logic [15:0] lfsr;
    logic [15:0] lfsr_rev;

    // Free-running Fibonacci LFSR, taps 16,14,13,11
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
        end
    end

    // Bit-reverse so the RAM word written later equals the LFSR state
    always_comb begin
        lfsr_rev = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            lfsr_rev[4'(i)] = lfsr[4'(15 - i)];
        end
    end
`else
    localparam logic [127:0] SEED_ROW = 128'(1) << SEED_X;
`endif

    // Next CA generation with wrap-around neighbours
    always_comb begin
        nxt_row = '0;
        for (int unsigned x = 0; x < 128; x++) begin
            nxt_row[7'(x)] = RULE[{cur_row[7'(x) - 7'd1],
                                   cur_row[7'(x)],
                                   cur_row[7'(x) + 7'd1]}];
        end
    end

    // Current word of cur_row, leftmost pixel in the MSB
    always_comb begin
        wr_word = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            wr_word[4'(15 - i)] = cur_row[{w, 4'(i)}];
        end
    end

    assign wr_en = (state == S_WRITE) && !prefetch_now && !rst;
    assign busy  = (state != S_IDLE);
    assign done  = (state == S_FIN);

    // Generation FSM: seed, then write 8 words per row and step the CA
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            w       <= '0;
            row     <= '0;
            cur_row <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        w     <= '0;
                        state <= S_SEED;
                    end
                end
                S_SEED: begin
`ifdef CA_LFSR_SEED_EN
                    cur_row[{w, 4'd0} +: 16] <= lfsr_rev;
                    if (w == 3'd7) begin
                        w     <= '0;
                        row   <= '0;
                        state <= S_WRITE;
                    end else begin
                        w <= w + 3'd1;
                    end
`else
                    cur_row <= SEED_ROW;
                    row     <= '0;
                    w       <= '0;
                    state   <= S_WRITE;
`endif
                end
                S_WRITE: begin
                    if (!prefetch_now) begin
                        if (w == 3'd7) begin
                            state <= (row == 7'd127) ? S_FIN : S_NEXT;
                        end else begin
                            w <= w + 3'd1;
                        end
                    end
                end
                S_NEXT: begin
                    cur_row <= nxt_row;
                    row     <= row + 7'd1;
                    w       <= '0;
                    state   <= S_WRITE;
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // RAM write port, blocked by any read in the same cycle
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{row, w}] <= wr_word;
        end
    end

    // Prefetch read port, one-cycle latency, holds between reads
    always_ff @(posedge clk) begin
        if (rst) begin
            prefetch_data <= '0;
        end else if (prefetch_now) begin
            prefetch_data <= mem[prefetch_addr];
        end
    end

endmodule

// File: tb/tb_ca_sprite_ram.sv
// Self-checking bench for ca_sprite_ram: RULE=30 and RULE=90 instances,
// reference image computed directly from the CA rule, frame schedule
// modelled as a list of slots (seed, 8 writes per row, step, finish).
module tb_ca_sprite_ram;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        pnow = 1'b0;
    logic [9:0]  paddr = '0;
    logic [15:0] pdata;
    logic        busy, done;
    logic [6:0]  row;

    logic        start90 = 1'b0;
    logic        pnow90 = 1'b0;
    logic [9:0]  paddr90 = '0;
    logic [15:0] pdata90;
    logic        busy90, done90;
    logic [6:0]  row90;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [15:0] exp_img [2][1024];
    bit          have [1024];

    always #5 clk = ~clk;

    ca_sprite_ram #(.RULE(8'd30), .SEED_X(64)) dut (
        .clk(clk), .rst(rst), .start(start),
        .prefetch_now(pnow), .prefetch_addr(paddr), .prefetch_data(pdata),
        .busy(busy), .done(done), .row(row)
    );

    ca_sprite_ram #(.RULE(8'd90), .SEED_X(64)) dut90 (
        .clk(clk), .rst(rst), .start(start90),
        .prefetch_now(pnow90), .prefetch_addr(paddr90), .prefetch_data(pdata90),
        .busy(busy90), .done(done90), .row(row90)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference image straight from the CA definition
    task automatic build_image(input int k, input int rule);
        int cells [128];
        int nc [128];
        for (int x = 0; x < 128; x++) cells[x] = 0;
        cells[64] = 1;
        for (int a = 0; a < 1024; a++) exp_img[k][a] = '0;
        for (int y = 0; y < 128; y++) begin
            for (int x = 0; x < 128; x++) begin
                if (cells[x] != 0) exp_img[k][y * 8 + x / 16][15 - (x % 16)] = 1'b1;
            end
            for (int x = 0; x < 128; x++) begin
                int idx;
                idx = cells[(x + 127) % 128] * 4 + cells[x] * 2 + cells[(x + 1) % 128];
                nc[x] = (rule >> idx) & 1;
            end
            for (int x = 0; x < 128; x++) cells[x] = nc[x];
        end
    endtask

    // Slot p of a frame: 0 seed, then per row 8 writes + 1 step, 1152 finish
    function automatic int slot_kind(input int p);
        if (p == 0) return 0;
        if (p >= 1152) return 3;
        return (((p - 1) % 9) < 8) ? 1 : 2;
    endfunction

    function automatic int slot_row(input int p);
        if (p >= 1152) return 127;
        return (p - 1) / 9;
    endfunction

    task automatic read30(input logic [9:0] a, output logic [15:0] d);
        pnow = 1'b1;
        paddr = a;
        tick;
        d = pdata;
        pnow = 1'b0;
    endtask

    task automatic read90(input logic [9:0] a, output logic [15:0] d);
        pnow90 = 1'b1;
        paddr90 = a;
        tick;
        d = pdata90;
        pnow90 = 1'b0;
    endtask

    task automatic check_image30(input string tag);
        logic [15:0] d;
        for (int a = 0; a < 1024; a++) begin
            read30(10'(a), d);
            check(tag, d, exp_img[0][a]);
        end
    endtask

    // mode 0: no reads; 1: five-cycle stall at addr 4 in row 10;
    // 2: random reads and ignored start pulses. abort_row >= 0 resets mid-frame.
    task automatic run_frame(input int mode, input int abort_row,
                             output int edges, output int stalls);
        int p;
        bit rd;
        bit stall_done;
        int stall_left;
        logic [15:0] expd;
        p = 0; edges = 0; stalls = 0; stall_done = 0; stall_left = 0;
        start = 1'b1;
        tick;
        start = 1'b0;
        while (1) begin
            if (edges > 3000) begin
                check("frame_timeout", edges, 1152);
                return;
            end
            check("done", done, (p == 1152) ? 1 : 0);
            check("busy", busy, 1);
            if (p >= 1) check("row", row, slot_row(p));
            if (p == 1152) break;
            if (abort_row >= 0 && slot_kind(p) == 1 && slot_row(p) == abort_row) begin
                rst = 1'b1;
                tick;
                rst = 1'b0;
                check("abort_busy", busy, 0);
                check("abort_row", row, 0);
                check("abort_done", done, 0);
                edges = -1;
                return;
            end
            rd = 0;
            if (mode == 1) begin
                if (!stall_done && slot_kind(p) == 1 && slot_row(p) == 10) begin
                    stall_done = 1;
                    stall_left = 5;
                end
                if (stall_left > 0) begin
                    rd = 1;
                    stall_left--;
                    paddr = 10'd4;
                end
            end else if (mode == 2) begin
                rd = ($urandom % 4) == 0;
                paddr = 10'($urandom_range(0, 1023));
                start = ($urandom % 50) == 0;
            end
            expd = have[paddr] ? exp_img[0][paddr] : 16'h0000;
            pnow = rd;
            tick;
            edges++;
            pnow = 1'b0;
            start = 1'b0;
            if (rd) check("mid_rdata", pdata, expd);
            if (slot_kind(p) == 1) begin
                if (rd) begin
                    stalls++;
                end else begin
                    have[slot_row(p) * 8 + ((p - 1) % 9)] = 1;
                    p++;
                end
            end else begin
                p++;
            end
        end
        tick;
        check("post_done", done, 0);
        check("post_busy", busy, 0);
    endtask

    initial begin
        int e, s;
        logic [15:0] d;
        build_image(0, 30);
        build_image(1, 90);
        for (int a = 0; a < 1024; a++) have[a] = 0;

        tick;
        tick;
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_row", row, 0);
        check("rst_pdata", pdata, 0);
        check("rst_busy90", busy90, 0);

        read30(10'd100, d);
        check("unwritten", d, 16'h0000);

        run_frame(0, -1, e, s);
        check("nominal_edges", e, 1152);

        read30(10'd4, d);  check("addr4", d, 16'h8000);
        read30(10'd11, d); check("addr11", d, 16'h0001);
        read30(10'd12, d); check("addr12", d, 16'hC000);
        for (int a = 8; a <= 15; a++) begin
            if (a != 11 && a != 12) begin
                read30(10'(a), d);
                check("row1_zero", d, 16'h0000);
            end
        end
        check_image30("img_nominal");

        pnow = 1'b1;
        paddr = 10'd4;
        tick;
        pnow = 1'b0;
        check("latency", pdata, 16'h8000);
        for (int i = 0; i < 3; i++) begin
            paddr = 10'($urandom_range(0, 1023));
            tick;
            check("hold", pdata, 16'h8000);
        end

        run_frame(1, -1, e, s);
        check("stall_edges", e, 1157);
        check_image30("img_stall");

        for (int k = 0; k < 2; k++) begin
            run_frame(2, -1, e, s);
            check("rand_edges", e, 1152 + s);
        end
        for (int i = 0; i < 40; i++) begin
            int a;
            a = $urandom_range(0, 1023);
            read30(10'(a), d);
            check("rand_read", d, exp_img[0][a]);
        end

        run_frame(0, 40, e, s);
        run_frame(0, -1, e, s);
        check("after_abort_edges", e, 1152);
        check_image30("img_abort");

        start90 = 1'b1;
        tick;
        start90 = 1'b0;
        e = 0;
        while (!done90 && e < 2000) begin
            tick;
            e++;
        end
        check("r90_edges", e, 1152);
        tick;
        for (int a = 512; a < 520; a++) begin
            read90(10'(a), d);
            check("r90_row64", d, 16'h0000);
        end
        for (int a = 504; a < 512; a++) begin
            read90(10'(a), d);
            check("r90_row63", d, 16'h5555);
        end
        for (int a = 0; a < 1024; a++) begin
            read90(10'(a), d);
            check("r90_img", d, exp_img[1][a]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
